// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared UART definitions: state encodings, width helper, parameter legality
package fifo_uart_tx_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        FETCH = S_FETCH,
        START = S_START,
        DATA  = S_DATA,
        STOP  = S_STOP
    } uart_state_e;

    localparam int DW_MIN      = 5;
    localparam int DW_MAX      = 9;
    localparam int CLK_DIV_MIN = 2;

    // Bits needed to hold the value; never less than one.
    function automatic int num_bits(input int value);
        int n;
        n = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

    function automatic bit params_legal(input int dw, input int clk_div, input int stop_bits);
        return (dw >= DW_MIN) && (dw <= DW_MAX) && (clk_div >= CLK_DIV_MIN) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read port: pop request, registered read data, empty flag
interface fifo_uart_tx_if #(
    parameter int DW = 8
);
    logic          fifo_rd_req;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;

    modport master (
        output fifo_rd_req,
        input  fifo_rd_data,
        input  fifo_empty
    );

    modport slave (
        input  fifo_rd_req,
        output fifo_rd_data,
        output fifo_empty
    );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - ClkDiv counter with synchronous clear and one-cycle tick on the last count
module baud_tick_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int ClkDiv = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int              CntW    = num_bits(ClkDiv - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count_q + CntW'(1);
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_q == CntLast) begin
            count_d = '0;
            tick    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops FIFO words and shifts them out as start/data/stop serial frames
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DW       = 8,
    parameter int ClkDiv   = 868,
    parameter int StopBits = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy
);
    localparam int             BitW     = num_bits(DW - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(DW - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(StopBits - 1);

    if (!params_legal(DW, ClkDiv, StopBits)) begin : g_param_check
        $error("fifo_uart_tx: DW, ClkDiv or StopBits out of range");
    end

    uart_state_e     state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic            tx_q, tx_d;
    logic            rd_req;
    logic            baud_clear;
    logic            baud_tick;

    // Counter idles at zero until the start bit so every bit period is exactly ClkDiv long.
    assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

    baud_tick_gen #(
        .ClkDiv(ClkDiv)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rd_req    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                rd_req = enable & ~fifo.fifo_empty & ~reset;
                if (rd_req) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d   = fifo.fifo_rd_data;
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = START;
            end
            START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LastBit) begin
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            STOP: begin
                // The bit counter is reused to count stop bits.
                if (baud_tick) begin
                    if (bit_cnt_q == LastStop) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign fifo.fifo_rd_req = rd_req;
    assign tx               = tx_q;
    assign busy             = (state_q != IDLE);
endmodule
